// File: rtl/kernel_mem_arbiter.sv
// kernel_mem_arbiter
//   Shares one external memory channel (one read and one write handshake)
//   between the two BRAM-style ports of an HLS kernel. The kernel advances
//   one cycle per kernel_step pulse. In each kernel cycle, port 0's access is
//   serviced first and port 1's second, so same-address accesses complete in
//   port order.
//
//   Ports
//     clk, reset               system clock, asynchronous active-high reset
//     read_base/write_base     byte base addresses; byte addr = base + (word << 2)
//     read_size_input          size field copied onto every issued request
//     ce/we/addr/d/q (0 and 1) kernel BRAM ports
//     kernel_step              one-cycle clock-enable pulse for the kernel
//     read_* / write_*         memory channel; *_enable are one-cycle pulses and
//                              *_ready are level-sensitive completions
//     busy                     high whenever the FSM is not in STEP
//
//   Optional: define KERNEL_MEM_ARB_STATS_EN to add the saturating counters
//   rd_count, wr_count and step_count.
module kernel_mem_arbiter #(
  parameter int ADDR_WID = 12,
  parameter int DATA_WID = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [63:0]         read_base,
  input  logic [63:0]         write_base,
  input  logic [63:0]         read_size_input,
  input  logic                ce0,
  input  logic                we0,
  input  logic [ADDR_WID-1:0] addr0,
  input  logic [DATA_WID-1:0] d0,
  output logic [DATA_WID-1:0] q0,
  input  logic                ce1,
  input  logic                we1,
  input  logic [ADDR_WID-1:0] addr1,
  input  logic [DATA_WID-1:0] d1,
  output logic [DATA_WID-1:0] q1,
  output logic                kernel_step,
  output logic                read_enable,
  output logic [63:0]         read_addr,
  output logic [63:0]         read_size_output,
  input  logic                read_ready,
  input  logic [DATA_WID-1:0] read_data,
  output logic                write_enable,
  output logic [63:0]         write_addr,
  output logic [63:0]         write_size,
  output logic [DATA_WID-1:0] write_data,
  input  logic                write_ready,
`ifdef KERNEL_MEM_ARB_STATS_EN
  output logic [31:0]         rd_count,
  output logic [31:0]         wr_count,
  output logic [31:0]         step_count,
`endif
  output logic                busy
);

  typedef enum logic [2:0] {STEP, SAMPLE, ISSUE0, WAIT0, ISSUE1, WAIT1} state_t;

  typedef struct packed {
    logic                ce;
    logic                we;
    logic [ADDR_WID-1:0] addr;
    logic [DATA_WID-1:0] d;
  } port_req_t;

  state_t                     state_q, state_d;
  port_req_t [1:0]            req_q, req_d;
  logic [1:0][DATA_WID-1:0]   q_q, q_d;
  logic                       step_q, step_d, busy_q, busy_d;
  logic                       rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [63:0]                rd_addr_q, rd_addr_d, rd_size_q, rd_size_d;
  logic [63:0]                wr_addr_q, wr_addr_d, wr_size_q, wr_size_d;
  logic [DATA_WID-1:0]        wr_data_q, wr_data_d;
  logic                       issue, issue_port, rd_done, wr_done;
  port_req_t                  sel;
  logic [63:0]                sel_off;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    q_d        = q_q;
    rd_en_d    = 1'b0;
    wr_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_size_d  = rd_size_q;
    wr_addr_d  = wr_addr_q;
    wr_size_d  = wr_size_q;
    wr_data_d  = wr_data_q;
    issue      = 1'b0;
    issue_port = 1'b0;
    rd_done    = 1'b0;
    wr_done    = 1'b0;
    unique case (state_q)
      STEP: state_d = SAMPLE;
      SAMPLE: begin
        req_d[0] = '{ce: ce0, we: we0, addr: addr0, d: d0};
        req_d[1] = '{ce: ce1, we: we1, addr: addr1, d: d1};
        if (ce0) begin
          state_d = ISSUE0;
          issue   = 1'b1;
        end else if (ce1) begin
          state_d    = ISSUE1;
          issue      = 1'b1;
          issue_port = 1'b1;
        end else begin
          state_d = STEP;
        end
      end
      // Ready seen while in ISSUEx is deliberately ignored: the request was
      // only just driven, so any ready then belongs to nothing of ours.
      ISSUE0: state_d = WAIT0;
      ISSUE1: state_d = WAIT1;
      WAIT0, WAIT1: begin
        // Only the ready matching the outstanding direction counts.
        if (req_q[state_q == WAIT1].we) wr_done = write_ready;
        else                            rd_done = read_ready;
        if (rd_done) q_d[state_q == WAIT1] = read_data;
        if (rd_done || wr_done) begin
          if (state_q == WAIT0 && req_q[1].ce) begin
            state_d    = ISSUE1;
            issue      = 1'b1;
            issue_port = 1'b1;
          end else begin
            state_d = STEP;
          end
        end
      end
      default: state_d = STEP;
    endcase

    // Request fields come from req_d so a request issued straight out of
    // SAMPLE uses the values being latched on this same edge.
    sel     = req_d[issue_port];
    sel_off = {{(64-ADDR_WID){1'b0}}, sel.addr} << 2;
    if (issue) begin
      if (sel.we) begin
        wr_en_d   = 1'b1;
        wr_addr_d = write_base + sel_off;
        wr_size_d = read_size_input;
        wr_data_d = sel.d;
      end else begin
        rd_en_d   = 1'b1;
        rd_addr_d = read_base + sel_off;
        rd_size_d = read_size_input;
      end
    end

    step_d = (state_d == STEP);
    busy_d = (state_d != STEP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= STEP;
      req_q     <= '0;
      q_q       <= '0;
      step_q    <= 1'b0;
      busy_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_size_q <= '0;
      wr_addr_q <= '0;
      wr_size_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      q_q       <= q_d;
      step_q    <= step_d;
      busy_q    <= busy_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      rd_addr_q <= rd_addr_d;
      rd_size_q <= rd_size_d;
      wr_addr_q <= wr_addr_d;
      wr_size_q <= wr_size_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign q0               = q_q[0];
  assign q1               = q_q[1];
  assign kernel_step      = step_q;
  assign busy             = busy_q;
  assign read_enable      = rd_en_q;
  assign read_addr        = rd_addr_q;
  assign read_size_output = rd_size_q;
  assign write_enable     = wr_en_q;
  assign write_addr       = wr_addr_q;
  assign write_size       = wr_size_q;
  assign write_data       = wr_data_q;

`ifdef KERNEL_MEM_ARB_STATS_EN
  logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, st_cnt_q, st_cnt_d;

  always_comb begin
    rd_cnt_d = (rd_done && rd_cnt_q != '1) ? rd_cnt_q + 32'd1 : rd_cnt_q;
    wr_cnt_d = (wr_done && wr_cnt_q != '1) ? wr_cnt_q + 32'd1 : wr_cnt_q;
    st_cnt_d = (step_q  && st_cnt_q != '1) ? st_cnt_q + 32'd1 : st_cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      st_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      st_cnt_q <= st_cnt_d;
    end
  end

  assign rd_count   = rd_cnt_q;
  assign wr_count   = wr_cnt_q;
  assign step_count = st_cnt_q;
`endif

endmodule

// File: tb/tb_kernel_mem_arbiter.sv
// Directed bench for kernel_mem_arbiter: a small memory responder supplies
// read/write ready with a programmable delay, and a monitor records enable
// pulses, so each step can be checked against hand-computed values.
module tb_kernel_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] read_base = '0, write_base = '0, read_size_input = '0;
  logic        ce0 = 0, we0 = 0, ce1 = 0, we1 = 0;
  logic [11:0] addr0 = '0, addr1 = '0;
  logic [31:0] d0 = '0, d1 = '0, q0, q1;
  logic        kernel_step, read_enable, write_enable, busy;
  logic [63:0] read_addr, read_size_output, write_addr, write_size;
  logic [31:0] write_data, read_data;
  logic        read_ready, write_ready;
`ifdef KERNEL_MEM_ARB_STATS_EN
  logic [31:0] rd_count, wr_count, step_count;
`endif

  // Ready/data sourcing: automatic responder or manual drive from the sequence.
  logic        auto_resp = 1'b1;
  logic        rr_auto = 0, wr_auto = 0, rr_man = 0, wr_man = 0;
  logic [31:0] rdata_auto = '0, rdata_man = '0;
  assign read_ready  = auto_resp ? rr_auto : rr_man;
  assign write_ready = auto_resp ? wr_auto : wr_man;
  assign read_data   = auto_resp ? rdata_auto : rdata_man;

  kernel_mem_arbiter #(.ADDR_WID(12), .DATA_WID(32)) dut (
    .clk(clk), .reset(reset),
    .read_base(read_base), .write_base(write_base), .read_size_input(read_size_input),
    .ce0(ce0), .we0(we0), .addr0(addr0), .d0(d0), .q0(q0),
    .ce1(ce1), .we1(we1), .addr1(addr1), .d1(d1), .q1(q1),
    .kernel_step(kernel_step),
    .read_enable(read_enable), .read_addr(read_addr), .read_size_output(read_size_output),
    .read_ready(read_ready), .read_data(read_data),
    .write_enable(write_enable), .write_addr(write_addr), .write_size(write_size),
    .write_data(write_data), .write_ready(write_ready),
`ifdef KERNEL_MEM_ARB_STATS_EN
    .rd_count(rd_count), .wr_count(wr_count), .step_count(step_count),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory model + responder
  logic [31:0] mem [logic [63:0]];
  int          rd_delay = 1, wr_delay = 1;
  int          rd_cnt = 0, wr_cnt = 0;
  logic        rd_pend = 0, wr_pend = 0;
  logic [63:0] rd_a, wr_a;
  logic [31:0] wr_d;

  always @(negedge clk) begin
    rr_auto = 1'b0;
    wr_auto = 1'b0;
    if (reset || !auto_resp) begin
      rd_pend = 1'b0;
      wr_pend = 1'b0;
    end else begin
      if (read_enable) begin
        rd_pend = 1'b1; rd_cnt = rd_delay; rd_a = read_addr;
      end else if (rd_pend) begin
        rd_cnt--;
        if (rd_cnt <= 0) begin
          rr_auto    = 1'b1;
          rdata_auto = mem.exists(rd_a) ? mem[rd_a] : 32'h0;
          rd_pend    = 1'b0;
        end
      end
      if (write_enable) begin
        wr_pend = 1'b1; wr_cnt = wr_delay; wr_a = write_addr; wr_d = write_data;
      end else if (wr_pend) begin
        wr_cnt--;
        if (wr_cnt <= 0) begin
          wr_auto = 1'b1;
          mem[wr_a] = wr_d;
          wr_pend = 1'b0;
        end
      end
    end
  end

  // Monitor
  int          cyc = 0, rd_pulses = 0, wr_pulses = 0, step_pulses = 0, rd_cyc = 0, wr_cyc = 0;
  logic        overlap = 0, dbl = 0, prev_rd = 0, prev_wr = 0;
  logic [63:0] last_rd_addr = '0, last_rd_size = '0, last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (kernel_step) step_pulses++;
    if (read_enable) begin
      rd_pulses++; rd_cyc = cyc; last_rd_addr = read_addr; last_rd_size = read_size_output;
    end
    if (write_enable) begin
      wr_pulses++; wr_cyc = cyc; last_wr_addr = write_addr; last_wr_data = write_data;
    end
    if (read_enable && write_enable) overlap = 1'b1;
    if ((read_enable && prev_rd) || (write_enable && prev_wr)) dbl = 1'b1;
    prev_rd = read_enable;
    prev_wr = write_enable;
  end

  // Waits (bounded) for the next negedge with kernel_step high.
  task automatic wait_step(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!kernel_step && n < 60);
    check("step_reached", kernel_step, 1'b1);
  endtask

  int n, r0, w0, s0;

  initial begin
    mem[64'h1014] = 32'hDEADBEEF;
    mem[64'h0]    = 32'h55;
    mem[64'h110]  = 32'h1234;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_kstep", kernel_step, 0);
    check("rst_busy", busy, 0);
    check("rst_rden", read_enable, 0);
    check("rst_wren", write_enable, 0);
    check("rst_raddr", read_addr, 0);
    check("rst_q0", q0, 0);

    // Release: SAMPLE first, kernel_step in the second cycle
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_c1_kstep", kernel_step, 0);
    check("post_rst_c1_busy", busy, 1);
    @(negedge clk);
    check("post_rst_c2_kstep", kernel_step, 1);
    check("post_rst_c2_busy", busy, 0);

    // Idle: one step every 2 clk, no memory traffic
    s0 = step_pulses;
    repeat (10) @(negedge clk);
    check("idle_steps", step_pulses - s0, 5);
    check("idle_rd_pulses", rd_pulses, 0);
    check("idle_wr_pulses", wr_pulses, 0);
    check("idle_at_step", kernel_step, 1);

    // Port 0 read, ready 3 clk after enable
    read_base = 64'h1000; read_size_input = 64'h40;
    ce0 = 1; we0 = 0; addr0 = 12'd5;
    rd_delay = 3;
    r0 = rd_pulses;
    wait_step(n);
    ce0 = 0;
    check("rd0_cycles", n, 6);
    check("rd0_addr", last_rd_addr, 64'h1014);
    check("rd0_size", last_rd_size, 64'h40);
    check("rd0_pulses", rd_pulses - r0, 1);
    check("rd0_q0", q0, 32'hDEADBEEF);

    // Dual: port 0 writes 7 to word 2, port 1 reads word 2
    rd_delay = 1; wr_delay = 1;
    read_base = 0; write_base = 0;
    ce0 = 1; we0 = 1; addr0 = 12'd2; d0 = 32'd7;
    ce1 = 1; we1 = 0; addr1 = 12'd2;
    r0 = rd_pulses; w0 = wr_pulses;
    wait_step(n);
    ce0 = 0; ce1 = 0;
    check("dual_cycles", n, 6);
    check("dual_wr_addr", last_wr_addr, 64'h8);
    check("dual_rd_addr", last_rd_addr, 64'h8);
    check("dual_wr_first", wr_cyc < rd_cyc, 1);
    check("dual_pulses", {32'(rd_pulses - r0), 32'(wr_pulses - w0)}, {32'd1, 32'd1});
    check("dual_q1", q1, 32'd7);

    // Both ports write the same word: port 1 lands last
    ce0 = 1; we0 = 1; addr0 = 12'd3; d0 = 32'hA;
    ce1 = 1; we1 = 1; addr1 = 12'd3; d1 = 32'hB;
    wait_step(n);
    ce0 = 0; ce1 = 0; we1 = 0;
    check("ww_cycles", n, 6);
    check("ww_mem", mem[64'hC], 32'hB);
    check("ww_q1_hold", q1, 32'd7);

    // Address wrap
    read_base = 64'hFFFF_FFFF_FFFF_FFFC;
    ce0 = 1; we0 = 0; addr0 = 12'd1;
    wait_step(n);
    ce0 = 0;
    check("wrap_addr", last_rd_addr, 64'h0);
    check("wrap_q0", q0, 32'h55);

    // Port 1 only, minimum latency (4 clk)
    read_base = 64'h100;
    ce1 = 1; we1 = 0; addr1 = 12'd4;
    wait_step(n);
    ce1 = 0;
    check("p1_cycles", n, 4);
    check("p1_addr", last_rd_addr, 64'h110);
    check("p1_q1", q1, 32'h1234);
    check("p1_q0_hold", q0, 32'h55);

    // Manual write: ready during ISSUE and stuck read_ready are ignored
    auto_resp = 1'b0;
    write_base = 64'h200;
    ce0 = 1; we0 = 1; addr0 = 12'd6; d0 = 32'h77;
    rr_man = 1; rdata_man = 32'hBAD;
    @(negedge clk);                      // SAMPLE
    @(negedge clk);                      // ISSUE0
    check("man_wren", write_enable, 1);
    check("man_waddr", write_addr, 64'h218);
    check("man_wdata", write_data, 32'h77);
    wr_man = 1;
    @(negedge clk);                      // WAIT0
    wr_man = 0;
    check("man_wait_busy", busy, 1);
    @(negedge clk);
    check("man_still_wait", kernel_step, 0);
    wr_man = 1;
    @(negedge clk);
    wr_man = 0; rr_man = 0; ce0 = 0; we0 = 0;
    check("man_step", kernel_step, 1);
    check("man_q0_hold", q0, 32'h55);
    check("no_overlap", overlap, 0);
    check("single_pulses", dbl, 0);

`ifdef KERNEL_MEM_ARB_STATS_EN
    check("stat_rd", rd_count, 32'd4);
    check("stat_wr", wr_count, 32'd4);
`endif

    // Reset in WAIT1
    read_base = 0;
    ce1 = 1; we1 = 0; addr1 = 12'd1;
    @(negedge clk);                      // SAMPLE
    @(negedge clk);                      // ISSUE1
    check("rw_rden", read_enable, 1);
    @(negedge clk);                      // WAIT1
    check("rw_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("rw_async_busy", busy, 0);
    check("rw_async_q1", q1, 0);
    check("rw_async_raddr", read_addr, 0);
    check("rw_async_kstep", kernel_step, 0);
    @(negedge clk);
    ce1 = 0;
    reset = 1'b0;
    rr_man = 1; rdata_man = 32'h99;
    @(negedge clk);
    check("rw_rel_c1_kstep", kernel_step, 0);
    @(negedge clk);
    rr_man = 0;
    check("rw_rel_c2_kstep", kernel_step, 1);
    check("rw_late_q1", q1, 0);
`ifdef KERNEL_MEM_ARB_STATS_EN
    check("stat_rd_rst", rd_count, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
